// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared types and constants for the synth voice blocks
package synth_pkg;

  typedef enum logic [1:0] {IDLE, RUN, STOP} osc_state_t;

  localparam int unsigned CLK_HZ      = 10_000_000;
  localparam int unsigned OSC_MIN_DIV = 2;

endpackage

// File: rtl/period_counter.sv
// rtl/period_counter.sv - period counter with wrap detect and boundary-only reload of the divide count
module period_counter
  import synth_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int MIN_DIV = OSC_MIN_DIV
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic             run,
  input  logic [DIV_W-1:0] div_in,
  output logic [DIV_W-1:0] count,
  output logic [DIV_W-1:0] div_act,
  output logic             wrap,
  output logic             div_ok
);

  assign div_ok = (div_in >= DIV_W'(MIN_DIV));
  assign wrap   = (count == div_act - DIV_W'(1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count   <= '0;
      div_act <= '0;
    end else if (load) begin
      count   <= '0;
      div_act <= div_in;
    end else if (run) begin
      if (wrap) begin
        count <= '0;
        // Pitch only changes on a period boundary, and only to a legal count
        if (div_ok && (div_in != div_act))
          div_act <= div_in;
      end else begin
        count <= count + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/note_oscillator.sv
// rtl/note_oscillator.sv - per-voice 50% duty square-wave oscillator with click-free pitch and release
module note_oscillator
  import synth_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int MIN_DIV = OSC_MIN_DIV
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_in,
  output logic             wave,
  output logic             period_tick,
  output logic             busy
);

  osc_state_t       state, state_nx;
  logic             load, run, wrap, div_ok;
  logic [DIV_W-1:0] count, div_act, half;

  period_counter #(
    .DIV_W   (DIV_W),
    .MIN_DIV (MIN_DIV)
  ) u_period_counter (
    .clk     (clk),
    .nrst    (nrst),
    .load    (load),
    .run     (run),
    .div_in  (div_in),
    .count   (count),
    .div_act (div_act),
    .wrap    (wrap),
    .div_ok  (div_ok)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    run      = 1'b0;
    case (state)
      IDLE: begin
        if (en && div_ok) begin
          state_nx = RUN;
          load     = 1'b1;
        end
      end
      RUN: begin
        run = 1'b1;
        // A release landing on the wrap cycle finishes the period straight into IDLE
        if (!en)
          state_nx = wrap ? IDLE : STOP;
      end
      STOP: begin
        run = 1'b1;
        if (en)
          state_nx = RUN;
        else if (wrap)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign half        = div_act >> 1;
  assign busy        = (state != IDLE);
  assign wave        = busy && (count < half);
  assign period_tick = busy && wrap;

endmodule
